// File: rtl/psram_pkg.sv
// ----------------------------------------------------------------------------
// psram_pkg
// Shared definitions for the PSRAM transaction sequencer:
//   - sequencer state encoding
//   - command/address (CA) bit positions in the 48-bit CA phase
//   - idle and running clock pair levels, RWDS read strobe pattern
//   - default timing parameters (latency, recovery, read timeout)
// ----------------------------------------------------------------------------
package psram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_WDATA,
    ST_RDATA,
    ST_HOLD,
    ST_RECOV
  } state_e;

  // CA phase layout (48 bits, sent MSB first as three 16-bit words)
  localparam int CA_W        = 48;
  localparam int CA_RW_BIT   = 47;  // 1 = read
  localparam int CA_AS_BIT   = 46;  // address space: memory
  localparam int CA_BT_BIT   = 45;  // linear burst
  localparam int CA_ROW_MSB  = 44;
  localparam int CA_ROW_LSB  = 16;
  localparam int CA_COL_MSB  = 2;

  // CK / CK# {rise, fall} half-cycle levels
  localparam logic [1:0] CK_IDLE  = 2'b00;
  localparam logic [1:0] CKN_IDLE = 2'b11;
  localparam logic [1:0] CK_RUN   = 2'b10;
  localparam logic [1:0] CKN_RUN  = 2'b01;

  // RWDS pattern that marks a valid read word
  localparam logic [1:0] RWDS_STROBE = 2'b10;

  // Default timing, in clk cycles
  localparam int LAT_CYC_DEF   = 6;
  localparam int RECOV_CYC_DEF = 4;
  localparam int RD_TO_DEF     = 32;

endpackage

// File: rtl/psram_ca_gen.sv
// ----------------------------------------------------------------------------
// psram_ca_gen
// Combinational packing of the 48-bit command/address word and selection of
// the 16-bit slice sent in CA cycle idx_i (0 = most significant word).
// Ports:
//   we_i    : 1 = write command
//   addr_i  : 32-bit word address
//   idx_i   : CA cycle index 0..2
//   word_o  : CA[47-16*idx -: 16]
// ----------------------------------------------------------------------------
module psram_ca_gen
  import psram_pkg::*;
(
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  idx_i,
  output logic [15:0] word_o
);

  logic [CA_W-1:0] ca;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    ca                         = '0;
    ca[CA_RW_BIT]              = ~we_i;
    ca[CA_AS_BIT]              = 1'b0;
    ca[CA_BT_BIT]              = 1'b1;
    ca[CA_ROW_MSB:CA_ROW_LSB]  = addr_i[31:3];
    ca[CA_COL_MSB:0]           = addr_i[2:0];
  end

  always_comb begin
    word_o = ca[15:0];
    case (idx_i)
      2'd0:    word_o = ca[47:32];
      2'd1:    word_o = ca[31:16];
      default: word_o = ca[15:0];
    endcase
  end

endmodule

// File: rtl/psram_seq.sv
// ----------------------------------------------------------------------------
// psram_seq
// PSRAM (HyperBus-style) transaction sequencer. Accepts one read or write
// burst command, drives CS#, the differential clock pair, CA words, latency,
// data phase, a one-cycle CS#-low hold and a CS#-high recovery period.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/ready/we/addr/len command handshake (len 0 = 256 words)
//   wr_data/wr_valid/wr_ready   write word stream (underrun masks the word)
//   rd_data/rd_valid/rd_err     read word strobe, timeout pulse
//   busy                        sequencer not idle
//   cs_n_o, cs_n_e              CS# level and drive enable
//   ck_o, ck_n_o                CK / CK# {rise, fall} half-cycle values
//   rwds_o, rwds_e, rwds_i      RWDS drive values/enable, sampled {rise, fall}
//   dq_wr, dq_e, dq_rd          DQ drive word, per-bit enable, captured word
//
// Configuration:
//   PSRAM_SEQ_RD_TIMEOUT_EN  when defined, RD_TO consecutive RDATA cycles
//                            without a read strobe pulse rd_err and end the
//                            burst; otherwise RDATA waits indefinitely.
// ----------------------------------------------------------------------------
module psram_seq
  import psram_pkg::*;
#(
  parameter int LAT_CYC   = LAT_CYC_DEF,
  parameter int RECOV_CYC = RECOV_CYC_DEF,
  parameter int RD_TO     = RD_TO_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        rd_err,
  output logic        busy,
  output logic        cs_n_o,
  output logic        cs_n_e,
  output logic [1:0]  ck_o,
  output logic [1:0]  ck_n_o,
  output logic [1:0]  rwds_o,
  output logic        rwds_e,
  input  logic [1:0]  rwds_i,
  output logic [15:0] dq_wr,
  output logic [7:0]  dq_e,
  input  logic [15:0] dq_rd
);

  if (LAT_CYC < 1 || RECOV_CYC < 1 || RD_TO < 1) begin : g_bad_param
    $error("psram_seq: LAT_CYC, RECOV_CYC and RD_TO must all be at least 1");
  end

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;     // CA index, latency and recovery countdown
  logic [7:0]  wcnt_q, wcnt_d;   // remaining burst words (0 means 256)
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic        lat_long_q, lat_long_d;
  logic        rd_valid_q, rd_valid_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic [1:0]  rst_sync_q;
  logic        run;
  logic        strobe;
  logic        to_hit;
  logic [15:0] ca_word;

  // Reset asserts at once but is released two clk edges later, so the
  // command port only opens once the whole design is out of reset.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign run    = rst_sync_q[1];
  assign strobe = (rwds_i == RWDS_STROBE);

`ifdef PSRAM_SEQ_RD_TIMEOUT_EN
  localparam int TO_W = $clog2(RD_TO + 1);

  logic [TO_W-1:0] to_q, to_d;

  // Counts consecutive strobe-less RDATA cycles; restarts on every word.
  always_comb begin
    to_d = '0;
    if (state_q == ST_RDATA && !strobe) to_d = to_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_q <= '0;
    else        to_q <= to_d;
  end

  assign to_hit = (state_q == ST_RDATA) && !strobe && (to_q == TO_W'(RD_TO - 1));
`else
  assign to_hit = 1'b0;
`endif

  assign rd_err = to_hit;

  psram_ca_gen u_ca_gen (
    .we_i   (we_q),
    .addr_i (addr_q),
    .idx_i  (cnt_q[1:0]),
    .word_o (ca_word)
  );

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    lat_long_d = lat_long_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = ST_CA;
          cnt_d   = '0;
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          wcnt_d  = cmd_len;
        end
      end
      ST_CA: begin
        // The device signals doubled latency on RWDS during the first CA word.
        if (cnt_q == 16'd0) lat_long_d = rwds_i[1];
        if (cnt_q == 16'd2) begin
          state_d = ST_LAT;
          cnt_d   = lat_long_q ? 16'(2 * LAT_CYC - 1) : 16'(LAT_CYC - 1);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_LAT: begin
        if (cnt_q == 16'd0) state_d = we_q ? ST_WDATA : ST_RDATA;
        else                cnt_d   = cnt_q - 16'd1;
      end
      ST_WDATA: begin
        // Underrun cycles still consume a word slot (sent masked).
        wcnt_d = wcnt_q - 8'd1;
        if (wcnt_q == 8'd1) state_d = ST_HOLD;
      end
      ST_RDATA: begin
        if (to_hit) begin
          state_d = ST_HOLD;
        end else if (strobe) begin
          wcnt_d = wcnt_q - 8'd1;
          if (wcnt_q == 8'd1) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        state_d = ST_RECOV;
        cnt_d   = 16'(RECOV_CYC - 1);
      end
      ST_RECOV: begin
        if (cnt_q == 16'd0) state_d = ST_IDLE;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read word appears the cycle after its strobe.
  assign rd_valid_d = (state_q == ST_RDATA) && strobe;
  assign rd_data_d  = rd_valid_d ? dq_rd : rd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      lat_long_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      lat_long_q <= lat_long_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Pin-level outputs, decoded from the current state
  logic clk_run;

  assign clk_run = (state_q == ST_CA) || (state_q == ST_LAT) ||
                   (state_q == ST_WDATA) || (state_q == ST_RDATA);

  always_comb begin
    ck_o   = clk_run ? CK_RUN  : CK_IDLE;
    ck_n_o = clk_run ? CKN_RUN : CKN_IDLE;
    cs_n_o = !(clk_run || state_q == ST_HOLD);
    dq_e   = '0;
    dq_wr  = '0;
    rwds_e = 1'b0;
    rwds_o = 2'b00;
    case (state_q)
      ST_CA: begin
        dq_e  = 8'hFF;
        dq_wr = ca_word;
      end
      ST_WDATA: begin
        dq_e   = 8'hFF;
        rwds_e = 1'b1;
        if (wr_valid) dq_wr  = wr_data;
        else          rwds_o = 2'b11;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE) && run;
  assign busy      = (state_q != ST_IDLE);
  assign wr_ready  = (state_q == ST_WDATA);
  assign cs_n_e    = rst_n;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_psram_seq.sv
// ----------------------------------------------------------------------------
// tb_psram_seq
// Self-checking bench for psram_seq. A transaction-level model turns each
// command (plus the randomly chosen RWDS/DQ/write stimulus) into the list of
// pin values every cycle must show; a compare process checks the DUT against
// that list at each falling edge.
// ----------------------------------------------------------------------------
module tb_psram_seq;

  localparam int LAT   = 6;
  localparam int RECOV = 4;
  localparam int RD_TO = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_err;
  logic        busy;
  logic        cs_n_o;
  logic        cs_n_e;
  logic [1:0]  ck_o;
  logic [1:0]  ck_n_o;
  logic [1:0]  rwds_o;
  logic        rwds_e;
  logic [1:0]  rwds_i = '0;
  logic [15:0] dq_wr;
  logic [7:0]  dq_e;
  logic [15:0] dq_rd = '0;

  always #5 clk = ~clk;

  psram_seq #(.LAT_CYC(LAT), .RECOV_CYC(RECOV), .RD_TO(RD_TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_err    (rd_err),
    .busy      (busy),
    .cs_n_o    (cs_n_o),
    .cs_n_e    (cs_n_e),
    .ck_o      (ck_o),
    .ck_n_o    (ck_n_o),
    .rwds_o    (rwds_o),
    .rwds_e    (rwds_e),
    .rwds_i    (rwds_i),
    .dq_wr     (dq_wr),
    .dq_e      (dq_e),
    .dq_rd     (dq_rd)
  );

  typedef struct {
    logic        cs_n, cs_n_e, cmd_ready, busy, wr_ready, rd_valid, rd_err;
    logic        rwds_e, chk_dq;
    logic [1:0]  ck, ckn, rwds_o;
    logic [7:0]  dq_e;
    logic [15:0] dq_wr, rd_data;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] wdata_plan[$];
  logic [15:0] rdata_plan[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          rdv_seen = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  // ---------------- model: per-cycle pin expectations ----------------
  function automatic exp_t rec_idle();
    exp_t e;
    e = '{default: '0};
    e.cs_n = 1'b1; e.cs_n_e = 1'b1; e.cmd_ready = 1'b1; e.ckn = 2'b11;
    return e;
  endfunction

  function automatic exp_t rec_reset();
    exp_t e;
    e = rec_idle();
    e.cs_n_e = 1'b0; e.cmd_ready = 1'b0;
    return e;
  endfunction

  function automatic exp_t rec_sel();  // CS# low, clock running
    exp_t e;
    e = '{default: '0};
    e.cs_n_e = 1'b1; e.busy = 1'b1; e.ck = 2'b10; e.ckn = 2'b01;
    return e;
  endfunction

  function automatic exp_t rec_off(input logic csn);  // clock stopped, busy
    exp_t e;
    e = '{default: '0};
    e.cs_n = csn; e.cs_n_e = 1'b1; e.busy = 1'b1; e.ckn = 2'b11;
    return e;
  endfunction

  function automatic logic [15:0] ca_word(input logic we, input logic [31:0] addr, input int k);
    logic [47:0] ca;
    ca = {~we, 1'b0, 1'b1, addr[31:3], 13'd0, addr[2:0]};
    return ca[47 - 16 * k -: 16];
  endfunction

  // ---------------- compare process ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rd_valid === 1'b1) rdv_seen++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cs_n_o",    cs_n_o,    e.cs_n);
        check("cs_n_e",    cs_n_e,    e.cs_n_e);
        check("cmd_ready", cmd_ready, e.cmd_ready);
        check("busy",      busy,      e.busy);
        check("wr_ready",  wr_ready,  e.wr_ready);
        check("rd_valid",  rd_valid,  e.rd_valid);
        check("rd_err",    rd_err,    e.rd_err);
        check("ck_o",      ck_o,      e.ck);
        check("ck_n_o",    ck_n_o,    e.ckn);
        check("dq_e",      dq_e,      e.dq_e);
        check("rwds_e",    rwds_e,    e.rwds_e);
        if (e.chk_dq)   check("dq_wr",   dq_wr,   e.dq_wr);
        if (e.rwds_e)   check("rwds_o",  rwds_o,  e.rwds_o);
        if (e.rd_valid) check("rd_data", rd_data, e.rd_data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    exp_t e;
    // Command offered right away must not be taken before the second edge.
    tick(); rst_n = 1'b1; cmd_valid = 1'b1; cmd_we = 1'b1;
    cmd_addr = $urandom; cmd_len = 8'd1;
    e = rec_idle(); e.cmd_ready = 1'b0;
    exp_q.push_back(e);
    tick(); exp_q.push_back(e);
  endtask

  task automatic do_reset_pulse();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst cs_n_o",   cs_n_o,   1'b1);
    check("rst cs_n_e",   cs_n_e,   1'b0);
    check("rst busy",     busy,     1'b0);
    check("rst wr_ready", wr_ready, 1'b0);
    check("rst rd_valid", rd_valid, 1'b0);
    check("rst rd_err",   rd_err,   1'b0);
    exp_q.push_back(rec_reset());
    cmd_valid = 1'b0; wr_valid = 1'b0; rwds_i = 2'b00;
    tick(); exp_q.push_back(rec_reset());
    release_reset();
  endtask

  // Command acceptance, three CA words and the latency phase.
  task automatic header(input logic we, input logic [31:0] addr, input logic [7:0] len,
                        input logic long_lat);
    exp_t e;
    tick();
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len;
    rwds_i = 2'($urandom);
    exp_q.push_back(rec_idle());
    for (int k = 0; k < 3; k++) begin
      tick();
      cmd_valid = 1'($urandom); cmd_we = 1'($urandom);
      cmd_addr = $urandom; cmd_len = 8'($urandom);
      rwds_i = (k == 0) ? {long_lat, 1'($urandom)} : 2'($urandom);
      e = rec_sel(); e.dq_e = 8'hFF; e.chk_dq = 1'b1; e.dq_wr = ca_word(we, addr, k);
      exp_q.push_back(e);
    end
    for (int i = 0; i < (long_lat ? 2 * LAT : LAT); i++) begin
      tick(); cmd_valid = 1'b0; rwds_i = 2'($urandom);
      exp_q.push_back(rec_sel());
    end
  endtask

  // HOLD, recovery and a short random idle gap.
  task automatic tail(input logic prev_s, input logic [15:0] prev_d);
    exp_t e;
    tick(); rwds_i = 2'b00; wr_valid = 1'b0;
    e = rec_off(1'b0); e.rd_valid = prev_s; e.rd_data = prev_d;
    exp_q.push_back(e);
    for (int i = 0; i < RECOV; i++) begin
      tick(); exp_q.push_back(rec_off(1'b1));
    end
    repeat ($urandom_range(0, 2)) begin
      tick(); exp_q.push_back(rec_idle());
    end
  endtask

  // under_idx: -1 no underrun, -2 random underruns, >=0 that word underruns.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [7:0] len,
                        input logic long_lat, input int under_idx);
    exp_t        e;
    int          nw, got, streak;
    logic        s, prev_s, wv;
    logic [15:0] prev_d;
    logic [1:0]  r;
    nw = (len == 8'd0) ? 256 : int'(len);
    prev_s = 1'b0; prev_d = '0;
    header(we, addr, len, long_lat);
    if (we) begin
      for (int i = 0; i < nw; i++) begin
        tick();
        wv = (under_idx == -2) ? ($urandom_range(0, 4) != 0) : (i != under_idx);
        wr_valid = wv;
        wr_data  = (wdata_plan.size() > 0) ? wdata_plan.pop_front() : 16'($urandom);
        e = rec_sel(); e.dq_e = 8'hFF; e.rwds_e = 1'b1; e.wr_ready = 1'b1;
        e.rwds_o = wv ? 2'b00 : 2'b11; e.chk_dq = wv; e.dq_wr = wr_data;
        exp_q.push_back(e);
      end
    end else begin
      got = 0; streak = 0;
      while (got < nw) begin
        tick();
        s = (streak >= 4) || ($urandom_range(0, 2) != 0);
        r = 2'($urandom);
        if (r == 2'b10) r = 2'b01;
        rwds_i = s ? 2'b10 : r;
        dq_rd  = (s && rdata_plan.size() > 0) ? rdata_plan.pop_front() : 16'($urandom);
        e = rec_sel(); e.rd_valid = prev_s; e.rd_data = prev_d;
        exp_q.push_back(e);
        prev_s = s; prev_d = dq_rd;
        if (s) begin got++; streak = 0; end
        else streak++;
      end
    end
    tail(prev_s, prev_d);
  endtask

  task automatic do_stuck_read();
    exp_t e;
    header(1'b0, $urandom, 8'd4, 1'b0);
`ifdef PSRAM_SEQ_RD_TIMEOUT_EN
    for (int c = 1; c <= RD_TO; c++) begin
      tick(); rwds_i = 2'b00; dq_rd = 16'($urandom);
      e = rec_sel(); e.rd_err = (c == RD_TO);
      exp_q.push_back(e);
    end
    tail(1'b0, 16'h0);
`else
    for (int c = 1; c <= RD_TO + 8; c++) begin
      tick(); rwds_i = 2'b00; dq_rd = 16'($urandom);
      e = rec_sel();
      exp_q.push_back(e);
    end
    do_reset_pulse();
`endif
  endtask

  task automatic do_write_reset();
    exp_t e;
    header(1'b1, $urandom, 8'd4, 1'b1);
    tick(); wr_valid = 1'b1; wr_data = 16'($urandom);
    e = rec_sel(); e.dq_e = 8'hFF; e.rwds_e = 1'b1; e.wr_ready = 1'b1;
    e.chk_dq = 1'b1; e.dq_wr = wr_data;
    exp_q.push_back(e);
    do_reset_pulse();  // lands in the second write word
  endtask

  initial begin
    int base;
    // Power-on reset
    tick(); exp_q.push_back(rec_reset());
    check("por cs_n_o",    cs_n_o,    1'b1);
    check("por cs_n_e",    cs_n_e,    1'b0);
    check("por busy",      busy,      1'b0);
    check("por cmd_ready", cmd_ready, 1'b0);
    check("por rd_valid",  rd_valid,  1'b0);
    check("por wr_ready",  wr_ready,  1'b0);
    tick(); exp_q.push_back(rec_reset());
    release_reset();

    // Hand-computed CA words for a write to word address 0x12
    check("ca word0", ca_word(1'b1, 32'h12, 0), 16'h2000);
    check("ca word1", ca_word(1'b1, 32'h12, 1), 16'h0002);
    check("ca word2", ca_word(1'b1, 32'h12, 2), 16'h0002);

    // Two-word write, short latency, fixed data
    wdata_plan.push_back(16'hA55A);
    wdata_plan.push_back(16'h1234);
    do_txn(1'b1, 32'h0000_0012, 8'd2, 1'b0, -1);

    // One-word read, doubled latency
    rdata_plan.push_back(16'hBEEF);
    base = rdv_seen;
    do_txn(1'b0, $urandom, 8'd1, 1'b1, -1);
    @(negedge clk); #1;
    check("len1 rd_valid pulses", rdv_seen - base, 1);

    // Three-word write with an underrun on the second word
    do_txn(1'b1, $urandom, 8'd3, 1'($urandom), 1);

    // Length 0 read is 256 words
    base = rdv_seen;
    do_txn(1'b0, $urandom, 8'd0, 1'($urandom), -1);
    @(negedge clk); #1;
    check("len0 rd_valid pulses", rdv_seen - base, 256);

    // Random traffic
    for (int t = 0; t < 24; t++)
      do_txn(1'($urandom), $urandom, 8'($urandom_range(1, 6)), 1'($urandom), -2);

    do_stuck_read();
    do_write_reset();
    do_txn(1'($urandom), $urandom, 8'($urandom_range(1, 6)), 1'($urandom), -2);

    tick(); cmd_valid = 1'b0; exp_q.push_back(rec_idle());
    repeat (3) @(negedge clk);
    #1;
    check("expectations drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
